// File: rtl/fib_bcd_conv.sv
// fib_bcd_conv
//   Converts one unsigned binary value at a time into packed BCD.
//   The conversion uses an iterative shift-add-3 (double-dabble) engine
//   that processes one input bit per clock.
//
// Parameters
//   DATA_W : binary input width. Must match the generator's fib_no width.
//   DIGITS : number of BCD digits. Must be >= ceil(DATA_W*log10(2)).
//
// Ports
//   clk       in   single clock; all state changes on its rising edge
//   rst       in   asynchronous, active-high reset
//   in_valid  in   in_data is valid
//   in_data   in   unsigned binary value to convert
//   in_ready  out  block can accept a value (IDLE only)
//   out_valid out  out_bcd holds a finished result (DONE only)
//   out_bcd   out  packed BCD; digit 0 (units) is in bits [3:0]
//   out_ready in   consumer accepts the result
//   busy      out  conversion in progress (SHIFT)
//
// Build option
//   FIB_BCD_LZ_BLANK_EN : when defined, leading-zero digits of the result
//   are replaced by 4'hF. Digit 0 is never blanked.
module fib_bcd_conv #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [DATA_W-1:0]  shift_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   out_bcd_r;

  logic [ACC_W-1:0]   adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic [ACC_W-1:0]   result_s;
  logic               last_step_s;

  // Add 3 to every digit >= 5; digits are independent, no carry between them.
  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    logic [3:0]       d;
    r = acc;
    for (int i = 0; i < DIGITS; i++) begin
      d = acc[4*i +: 4];
      if (d >= 4'd5) begin
        r[4*i +: 4] = d + 4'd3;
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

`ifdef FIB_BCD_LZ_BLANK_EN
  // Replace zero digits above the most significant non-zero digit with 4'hF.
  function automatic logic [ACC_W-1:0] blank_leading(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    logic             seen;
    r    = acc;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!seen && (acc[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        seen = 1'b1;
      end
    end
    return r;
  endfunction
`endif

  // One double-dabble step: adjust digits, then shift {acc, shift} left by one.
  always_comb begin
    adj_s       = add3_digits(acc_r);
    acc_shift_s = {adj_s[ACC_W-2:0], shift_r[DATA_W-1]};
    last_step_s = (cnt_r == CNT_W'(1));
`ifdef FIB_BCD_LZ_BLANK_EN
    result_s    = blank_leading(acc_shift_s);
`else
    result_s    = acc_shift_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_step_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: load on accept, shift while converting, capture result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= {DATA_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      out_bcd_r <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            shift_r <= in_data;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= CNT_W'(DATA_W);
          end
        end
        ST_SHIFT: begin
          shift_r <= {shift_r[DATA_W-2:0], 1'b0};
          acc_r   <= acc_shift_s;
          cnt_r   <= cnt_r - CNT_W'(1);
          // out_bcd only changes on entry to DONE, so it holds through stalls
          // and keeps the last result after the handshake.
          if (last_step_s) begin
            out_bcd_r <= result_s;
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_SHIFT);
  assign out_valid = (state_r == ST_DONE);
  assign out_bcd   = out_bcd_r;

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Self-checking bench for fib_bcd_conv: directed values, the Fibonacci stream
// with stalls, random values, mid-conversion reset and back-to-back throughput.
module tb_fib_bcd_conv;

  localparam int DATA_W = 20;
  localparam int DIGITS = 7;
  localparam int BCD_W  = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [BCD_W-1:0]  out_bcd;
  logic              out_ready = 1'b0;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  fib_bcd_conv #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bcd   (out_bcd),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Reference: decimal digits by repeated division, optional blanking above
  // the number's decimal length.
  function automatic logic [BCD_W-1:0] ref_bcd(input int unsigned v);
    int unsigned      x;
    logic [BCD_W-1:0] r;
`ifdef FIB_BCD_LZ_BLANK_EN
    int               ndig;
`endif
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef FIB_BCD_LZ_BLANK_EN
    ndig = 0;
    x = v;
    while (x > 0) begin
      ndig++;
      x = x / 10;
    end
    if (ndig == 0) ndig = 1;
    for (int i = ndig; i < DIGITS; i++) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // One full transaction: accept, measure latency, check result, optional
  // stall, then handshake. pulse_extra raises in_valid again during SHIFT.
  task automatic convert(input int unsigned v, input int stall, input bit pulse_extra);
    int               lat;
    logic [BCD_W-1:0] exp;
    exp = ref_bcd(v);
    wait_ready();
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    tick();
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = (pulse_extra && lat == 3) ? 1'b1 : 1'b0;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'd20);
    check("out_bcd", 32'(out_bcd), 32'(exp));
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_bcd", 32'(out_bcd), 32'(exp));
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_hs_valid", {31'd0, out_valid}, 32'd0);
    check("after_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("after_hs_hold", 32'(out_bcd), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned fa, fb, fc;
    int          acc_times[$];
    logic [BCD_W-1:0] exp_q[$];
    int          n;
    bit          acc_now;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    rst = 1'b0;
    tick();

    // Directed values
    convert(0, 0, 1'b0);
    convert(6765, 3, 1'b0);
    convert(1048575, 0, 1'b0);

    // F1..F25 streamed, every third result stalled 10 cycles, stray in_valid pulses
    fa = 1;
    fb = 1;
    for (int i = 1; i <= 25; i++) begin
      convert(fa, (i % 3 == 0) ? 10 : 0, 1'b1);
      fc = fa + fb;
      fa = fb;
      fb = fc;
    end

    // Random values
    for (int i = 0; i < 12; i++) begin
      convert($urandom_range(0, 1048575), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Reset during the 7th SHIFT cycle of 6765
    wait_ready();
    in_valid = 1'b1;
    in_data  = DATA_W'(6765);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_bcd", 32'(out_bcd), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    convert(89, 0, 1'b0);

    // Throughput: out_ready high, in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DATA_W'($urandom);
    n = 0;
    while (acc_times.size() < 5 && n < 400) begin
      acc_now = 1'b0;
      if (out_valid) begin
        if (exp_q.size() > 0) check("tput_bcd", 32'(out_bcd), 32'(exp_q.pop_front()));
        else check("tput_unexpected_out", 32'd1, 32'd0 + {31'd0, in_ready});
      end
      if (in_ready) begin
        acc_times.push_back(cyc);
        exp_q.push_back(ref_bcd(32'(in_data)));
        acc_now = 1'b1;
      end
      tick();
      if (acc_now) in_data = DATA_W'($urandom);
      n++;
    end
    in_valid = 1'b0;
    check("tput_accepts", 32'(acc_times.size()), 32'd5);
    for (int i = 1; i < acc_times.size(); i++) begin
      check("tput_period", 32'(acc_times[i] - acc_times[i-1]), 32'd22);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("tput_last_valid", {31'd0, out_valid}, 32'd1);
    if (exp_q.size() > 0) check("tput_last_bcd", 32'(out_bcd), 32'(exp_q.pop_front()));
    else check("tput_queue", 32'(exp_q.size()), 32'd1);
    tick();
    out_ready = 1'b0;
    check("tput_end_idle", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
